sdram_init_refresh: RTL and testbench
=====================================

Name: sdram_init_refresh

Overview:
- Parametrised SDRAM command sequencer for the single-chip-select SDR SDRAM command bus.
- Runs the power-up sequence: init wait, PRECHARGE ALL, N AUTO REFRESH, LOAD MODE REGISTER. Mode fields and all timings are parameters.
- After init it schedules periodic refresh and gains the bus from the host controller through a req/ack handshake.
- Sits between the PLL-clocked host logic and the DRAM pins; the host drives the bus only while it holds the bus.

Parameters:
- ADDR_W, 13, DRAM address width (>=11).
- BA_W, 2, bank address width.
- T_INIT_CYC, 10000, power-up NOP cycles before first PRECHARGE.
- T_RP, 2, PRECHARGE to next command, in cycles (>=1).
- T_RC, 7, AUTO REFRESH to next command, in cycles (>=1).
- T_MRD, 2, LOAD MODE to next command, in cycles (>=1).
- INIT_REFRESH, 8, AUTO REFRESH count during init (>=1).
- REF_INTERVAL, 780, cycles between refresh obligations.
- CAS_LAT, 2, mode reg A[6:4].
- BURST_LEN, 3'b111, mode reg A[2:0].
- BURST_TYPE, 0, mode reg A[3].
- WRITE_BURST, 0, mode reg A[9]; 0 = burst writes.

Ports:
- clk, in, 1: command clock.
- rst_n, in, 1: asynchronous active-low reset.
- cmd_cs_n, out, 1: chip select.
- cmd_ras_n, out, 1: row strobe.
- cmd_cas_n, out, 1: column strobe.
- cmd_we_n, out, 1: write enable.
- cmd_cke, out, 1: clock enable.
- cmd_ba, out, BA_W: bank address.
- cmd_addr, out, ADDR_W: address.
- init_done, out, 1: init complete; host may issue commands.
- ref_req, out, 1: refresh pending; host must finish its burst.
- ref_ack, in, 1: host has released the bus (all rows closed or closable).
- ref_busy, out, 1: sequencer owns the bus; host drives NOP.
- ref_overrun, out, 1: sticky; an obligation was lost.

Behaviour:
- Reset (async, rst_n=0) drives outputs to NOP: cs_n=0, ras_n=cas_n=we_n=1, cke=1, ba=0, addr=0, init_done=0, ref_req=0, ref_busy=1, ref_overrun=0, state=INIT_WAIT, timer=T_INIT_CYC-1. Reset mid-operation restarts the full init.
- All outputs are registered. Each command is held exactly one cycle, then NOP while a down-counter runs. A command at cycle n permits the next command at n+T, so timer load = T-1.
- States and transitions:
  - INIT_WAIT: NOP until timer=0 -> PRE.
  - PRE: PRECHARGE (ras_n=0, we_n=0, addr[10]=1) -> PRE_WAIT(T_RP-1).
  - PRE_WAIT: -> AREF if initialising, else -> RREF.
  - AREF: AUTO REFRESH (ras_n=cas_n=0) -> AREF_WAIT(T_RC-1), counter--.
  - AREF_WAIT: -> AREF while counter>0, else -> LMR.
  - LMR: LOAD MODE (ras_n=cas_n=we_n=0), ba=0, addr={0, WRITE_BURST, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN} -> MRD_WAIT(T_MRD-1).
  - MRD_WAIT: -> IDLE; init_done=1 and ref_busy=0 on entry to IDLE.
  - IDLE: if pending>0 then ref_req=1; when ref_ack=1 sampled -> PRE with ref_busy=1 and ref_req=0 on the same edge.
  - RREF: AUTO REFRESH -> RREF_WAIT(T_RC-1).
  - RREF_WAIT: pending-- on exit; -> IDLE with ref_busy=0.
- ref_ack is ignored while ref_req=0. The host keeps ref_ack high for at most until ref_busy rises.
- Interval counter starts on init_done and free-runs modulo REF_INTERVAL. Each wrap increments pending.
- A wrap coinciding with a decrement leaves pending unchanged.
- A wrap with pending already at its maximum sets ref_overrun; pending saturates.
- Pending maximum is 1 without the optional feature.

Optional Feature:
- Macro SDRAM_REF_DEBT_EN.
- Defined:
  - Pending is a 4-bit debt counter, maximum 8 (JEDEC postponement limit).
  - After one ack, the sequencer issues one PRECHARGE followed by back-to-back AUTO REFRESH commands (T_RC spaced) until debt=0, then releases the bus.
  - Overrun only on a wrap at debt=8.
- Undefined:
  - Single pending flag; one refresh per ack.

Decomposition:
- Package sdram_pkg:
  - Command encodings as 4-bit {cs_n, ras_n, cas_n, we_n} constants: NOP, PRECHARGE, AREF, LMR, ACTIVE, READ, WRITE.
  - State enum typedef.
  - Mode-register field assembly function.
- Sub-module sdram_timer: loadable down-counter with a zero flag.
  - Instantiated twice: command spacing and refresh interval.

Test Plan:
- Params T_INIT_CYC=20, T_RP=2, T_RC=3, T_MRD=2, INIT_REFRESH=2; release rst_n -> PRECHARGE at cycle 20, AREF at 22 and 25, LMR at 28 with addr=0x027, init_done=1 at 30.
- Assert rst_n=0 during second AREF -> outputs return to NOP and init_done=0 asynchronously; full sequence restarts at cycle 20 after release.
- REF_INTERVAL=50, ref_ack given 3 cycles after ref_req -> PRECHARGE the cycle after ack sampled, AREF 2 later, ref_busy low 3 cycles after AREF, ref_req cleared.
- ref_ack tied 0 for 120 cycles, REF_INTERVAL=50 -> without macro ref_overrun=1 at the 2nd wrap; with SDRAM_REF_DEBT_EN debt=2 and no overrun.
- SDRAM_REF_DEBT_EN, debt=3, then ack -> one PRECHARGE, three AREF spaced T_RC=3 apart, debt=0, ref_busy drops.
- Interval wrap on the same cycle RREF_WAIT exits with pending=1 -> pending stays 1, ref_req reasserts the next cycle, no overrun.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, sequencer state codes and mode-register assembly.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LMR       = 4'b0000,
        CMD_AREF      = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_NOP       = 4'b0111
    } cmd_e;

    typedef logic [3:0] state_t;

    localparam state_t ST_INIT_WAIT = 4'd0;
    localparam state_t ST_PRE       = 4'd1;
    localparam state_t ST_PRE_WAIT  = 4'd2;
    localparam state_t ST_AREF      = 4'd3;
    localparam state_t ST_AREF_WAIT = 4'd4;
    localparam state_t ST_LMR       = 4'd5;
    localparam state_t ST_MRD_WAIT  = 4'd6;
    localparam state_t ST_IDLE      = 4'd7;
    localparam state_t ST_RREF      = 4'd8;
    localparam state_t ST_RREF_WAIT = 4'd9;

    function automatic logic [9:0] mode_word(input logic [2:0] cas_lat,
                                             input logic       burst_type,
                                             input logic [2:0] burst_len,
                                             input logic       write_burst);
        return {write_burst, 2'b00, cas_lat, burst_type, burst_len};
    endfunction

endpackage

// File: rtl/sdram_timer.sv
// Loadable down-counter that stops at zero and flags it; zero is valid the cycle after the load.
// Latency: load takes effect next cycle. No backpressure.
// A load always wins over counting.
module sdram_timer #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up sequencer and periodic refresh scheduler; optional refresh debt via SDRAM_REF_DEBT_EN.
// Latency: all outputs registered; a sampled ref_ack issues PRECHARGE on the following cycle.
// Backpressure: refresh waits in ref_req until the host acks; lost obligations set sticky ref_overrun.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int         ADDR_W       = 13,
    parameter int         BA_W         = 2,
    parameter int         T_INIT_CYC   = 10000,
    parameter int         T_RP         = 2,
    parameter int         T_RC         = 7,
    parameter int         T_MRD        = 2,
    parameter int         INIT_REFRESH = 8,
    parameter int         REF_INTERVAL = 780,
    parameter int         CAS_LAT      = 2,
    parameter logic [2:0] BURST_LEN    = 3'b111,
    parameter int         BURST_TYPE   = 0,
    parameter int         WRITE_BURST  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              cmd_cs_n,
    output logic              cmd_ras_n,
    output logic              cmd_cas_n,
    output logic              cmd_we_n,
    output logic              cmd_cke,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              init_done,
    output logic              ref_req,
    input  logic              ref_ack,
    output logic              ref_busy,
    output logic              ref_overrun
);

`ifdef SDRAM_REF_DEBT_EN
    localparam int           PW       = 4;
    localparam logic [PW-1:0] PEND_MAX = PW'(8);
    localparam bit           DEBT     = 1'b1;
`else
    localparam int           PW       = 1;
    localparam logic [PW-1:0] PEND_MAX = PW'(1);
    localparam bit           DEBT     = 1'b0;
`endif

    localparam int         CW   = $clog2(T_INIT_CYC + T_RP + T_RC + T_MRD + 1);
    localparam int         IW   = $clog2(REF_INTERVAL + 1);
    localparam int         RW   = $clog2(INIT_REFRESH + 1);
    localparam logic [9:0] MODE = mode_word(3'(CAS_LAT), 1'(BURST_TYPE), BURST_LEN, 1'(WRITE_BURST));

    state_t            state, eff, nxt;
    logic              tmr_load, tmr_zero, iv_zero, iv_load, wrap, dec;
    logic [CW-1:0]     tmr_val;
    logic [RW-1:0]     aref_left;
    logic [PW-1:0]     pending, pending_nxt;
    cmd_e              cmd_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    // A command whose spacing is a single cycle has already served its wait,
    // so it is treated as its wait state to avoid a spare NOP.
    always_comb begin
        eff = state;
        if (tmr_zero) begin
            case (state)
                ST_PRE:  eff = ST_PRE_WAIT;
                ST_AREF: eff = ST_AREF_WAIT;
                ST_LMR:  eff = ST_MRD_WAIT;
                ST_RREF: eff = ST_RREF_WAIT;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt = eff;
        case (eff)
            ST_INIT_WAIT: if (tmr_zero) nxt = ST_PRE;
            ST_PRE:       nxt = ST_PRE_WAIT;
            ST_PRE_WAIT:  if (tmr_zero) nxt = init_done ? ST_RREF : ST_AREF;
            ST_AREF:      nxt = ST_AREF_WAIT;
            ST_AREF_WAIT: if (tmr_zero) nxt = (aref_left != '0) ? ST_AREF : ST_LMR;
            ST_LMR:       nxt = ST_MRD_WAIT;
            ST_MRD_WAIT:  if (tmr_zero) nxt = ST_IDLE;
            ST_IDLE:      if (ref_req && ref_ack) nxt = ST_PRE;
            ST_RREF:      nxt = ST_RREF_WAIT;
            ST_RREF_WAIT: if (tmr_zero) nxt = (DEBT && (pending > PW'(1))) ? ST_RREF : ST_IDLE;
            default:      nxt = ST_INIT_WAIT;
        endcase
    end

    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = '0;
        cmd_nxt  = CMD_NOP;
        addr_nxt = '0;
        case (nxt)
            ST_PRE: begin
                tmr_val      = CW'(T_RP - 1);
                cmd_nxt      = CMD_PRECHARGE;
                addr_nxt[10] = 1'b1;
            end
            ST_AREF, ST_RREF: begin
                tmr_val = CW'(T_RC - 1);
                cmd_nxt = CMD_AREF;
            end
            ST_LMR: begin
                tmr_val  = CW'(T_MRD - 1);
                cmd_nxt  = CMD_LMR;
                addr_nxt = ADDR_W'(MODE);
            end
            default: tmr_load = 1'b0;
        endcase
    end

    always_comb begin
        wrap        = init_done && iv_zero;
        dec         = (eff == ST_RREF_WAIT) && tmr_zero;
        pending_nxt = pending;
        if (wrap && !dec) begin
            if (pending != PEND_MAX) pending_nxt = pending + 1'b1;
        end else if (dec && !wrap) begin
            pending_nxt = pending - 1'b1;
        end
    end

    assign iv_load = !init_done || iv_zero;

    sdram_timer #(.W(CW), .RST_VAL(CW'(T_INIT_CYC - 1))) u_cmd_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    sdram_timer #(.W(IW), .RST_VAL(IW'(REF_INTERVAL - 1))) u_ref_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (iv_load),
        .load_val (IW'(REF_INTERVAL - 1)),
        .zero     (iv_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT_WAIT;
            aref_left   <= RW'(INIT_REFRESH);
            pending     <= '0;
            {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_NOP;
            cmd_cke     <= 1'b1;
            cmd_ba      <= '0;
            cmd_addr    <= '0;
            init_done   <= 1'b0;
            ref_req     <= 1'b0;
            ref_busy    <= 1'b1;
            ref_overrun <= 1'b0;
        end else begin
            state       <= nxt;
            if (nxt == ST_AREF) aref_left <= aref_left - 1'b1;
            pending     <= pending_nxt;
            {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= cmd_nxt;
            cmd_cke     <= 1'b1;
            cmd_ba      <= '0;
            cmd_addr    <= addr_nxt;
            init_done   <= init_done | (nxt == ST_IDLE);
            ref_req     <= (nxt == ST_IDLE) && (pending_nxt != '0);
            ref_busy    <= (nxt != ST_IDLE);
            ref_overrun <= ref_overrun | (wrap && !dec && (pending == PEND_MAX));
        end
    end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Bench for sdram_init_refresh: time-based model of the command schedule checked every cycle,
// plus directed init, reset, ack-latency, overrun/debt and wrap-collision scenarios.
module tb_sdram_init_refresh;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int T_INIT = 20;
    localparam int T_RP   = 2;
    localparam int T_RC   = 3;
    localparam int T_MRD  = 2;
    localparam int NREF   = 2;
    localparam int REF    = 50;
`ifdef SDRAM_REF_DEBT_EN
    localparam int PMAX = 8;
    localparam bit DEBT = 1'b1;
`else
    localparam int PMAX = 1;
    localparam bit DEBT = 1'b0;
`endif
    // First cycle with init_done high.
    localparam int D = T_INIT + T_RP + NREF * T_RC + T_MRD;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ARF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic              clk, rst_n, ref_ack;
    logic              cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_cke;
    logic [BA_W-1:0]   cmd_ba;
    logic [ADDR_W-1:0] cmd_addr;
    logic              init_done, ref_req, ref_busy, ref_overrun;
    logic [3:0]        cmd;

    assign cmd = {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n};

    sdram_init_refresh #(
        .ADDR_W(ADDR_W), .BA_W(BA_W), .T_INIT_CYC(T_INIT), .T_RP(T_RP), .T_RC(T_RC),
        .T_MRD(T_MRD), .INIT_REFRESH(NREF), .REF_INTERVAL(REF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_cs_n(cmd_cs_n), .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
        .cmd_cke(cmd_cke), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .init_done(init_done), .ref_req(ref_req), .ref_ack(ref_ack),
        .ref_busy(ref_busy), .ref_overrun(ref_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // Model: cycle index since reset release, pending obligations, refresh window timing.
    int mc, pend, in_ref, pre_t, aref_t;
    bit ovr;
    int cur_c;
    logic [3:0] cur_cmd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, mc, act, exp);
        end
    endtask

    task automatic model_reset();
        mc = 0; pend = 0; in_ref = 0; ovr = 0; pre_t = -100; aref_t = -100;
    endtask

    function automatic logic [3:0] init_cmd(input int cc);
        int k;
        if (cc == T_INIT) return C_PRE;
        if (cc == D - T_MRD) return C_LMR;
        k = cc - (T_INIT + T_RP);
        if (k >= 0 && (k % T_RC) == 0 && (k / T_RC) < NREF) return C_ARF;
        return C_NOP;
    endfunction

    task automatic compare();
        logic [3:0] ecmd;
        logic [ADDR_W-1:0] eaddr;
        bit edone, ebusy, ereq;
        if (mc < D) begin
            ecmd = init_cmd(mc); edone = 0; ebusy = 1; ereq = 0;
        end else begin
            edone = 1;
            if (in_ref != 0) begin
                ebusy = 1; ereq = 0;
                ecmd = (mc == pre_t) ? C_PRE : (mc == aref_t) ? C_ARF : C_NOP;
            end else begin
                ebusy = 0; ereq = (pend > 0); ecmd = C_NOP;
            end
        end
        eaddr = (ecmd == C_PRE) ? 13'h400 : (ecmd == C_LMR) ? 13'h027 : 13'h000;
        check("cmd", cmd, ecmd);
        check("addr", cmd_addr, eaddr);
        check("ba", cmd_ba, 0);
        check("cke", cmd_cke, 1);
        check("init_done", init_done, edone);
        check("ref_req", ref_req, ereq);
        check("ref_busy", ref_busy, ebusy);
        check("ref_overrun", ref_overrun, ovr);
    endtask

    task automatic advance(input bit a);
        bit dec, wrap;
        dec = 0; wrap = 0;
        if (mc >= D) begin
            if (in_ref != 0) begin
                if (mc == aref_t + T_RC - 1) begin
                    dec = 1;
                    if (DEBT && pend > 1) aref_t += T_RC;
                    else in_ref = 0;
                end
            end else if (pend > 0 && a) begin
                in_ref = 1; pre_t = mc + 1; aref_t = mc + 1 + T_RP;
            end
            wrap = ((mc - D) % REF) == REF - 1;
            if (wrap && !dec) begin
                if (pend == PMAX) ovr = 1; else pend++;
            end else if (dec && !wrap) begin
                pend--;
            end
        end
        mc++;
    endtask

    task automatic step(input bit a);
        @(negedge clk);
        cur_c = mc; cur_cmd = cmd;
        compare();
        ref_ack = a;
        advance(a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; ref_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd", cmd, C_NOP);
        check("rst_init_done", init_done, 0);
        check("rst_busy", ref_busy, 1);
        check("rst_req", ref_req, 0);
        check("rst_overrun", ref_overrun, 0);
        #1 rst_n = 1;
        model_reset();
    endtask

    int first_pre, first_arf, lmr_c, done_c, req_c, ack_c, drop_c, narf;
    logic [ADDR_W-1:0] lmr_addr;
    bit req_after_ack;

    initial begin
        rst_n = 0; ref_ack = 0;
        model_reset();

        // Init sequence, then reset during the second AREF.
        do_reset();
        first_pre = -1; first_arf = -1;
        for (int i = 0; i <= 25; i++) begin
            step(0);
            if (cur_cmd == C_PRE && first_pre < 0) first_pre = cur_c;
            if (cur_cmd == C_ARF && first_arf < 0) first_arf = cur_c;
        end
        check("first_precharge_cycle", first_pre, 20);
        check("first_aref_cycle", first_arf, 22);
        check("second_aref_at_25", cur_cmd, C_ARF);
        #1 rst_n = 0;
        #1;
        check("async_rst_cmd", cmd, C_NOP);
        check("async_rst_init_done", init_done, 0);
        check("async_rst_busy", ref_busy, 1);

        // Restarted init, then no ack for two-plus wraps.
        do_reset();
        lmr_c = -1; done_c = -1; first_pre = -1; lmr_addr = '0;
        for (int i = 0; i < D + 155; i++) begin
            step(0);
            if (cur_cmd == C_PRE && first_pre < 0) first_pre = cur_c;
            if (cur_cmd == C_LMR && lmr_c < 0) begin lmr_c = cur_c; lmr_addr = cmd_addr; end
            if (init_done && done_c < 0) done_c = cur_c;
            if (cur_c == D + 120) check("overrun_after_2_wraps", ref_overrun, DEBT ? 0 : 1);
        end
        check("restart_precharge_cycle", first_pre, 20);
        check("lmr_cycle", lmr_c, 28);
        check("lmr_addr", lmr_addr, 13'h027);
        check("init_done_cycle", done_c, 30);
        step(1);
        ack_c = cur_c; narf = 0; drop_c = -1;
        for (int i = 0; i < 40 && drop_c < 0; i++) begin
            step(0);
            if (cur_cmd == C_ARF) narf++;
            if (!ref_busy) drop_c = cur_c;
        end
        check("busy_released_after_debt", (drop_c > ack_c), 1);
        check("arefs_per_ack", narf, DEBT ? 3 : 1);

        // Ack three cycles after ref_req.
        do_reset();
        req_c = -1;
        for (int i = 0; i < D + REF + 20 && req_c < 0; i++) begin
            step(0);
            if (ref_req) req_c = cur_c;
        end
        check("first_req_cycle", req_c, D + REF);
        step(0); step(0); step(1);
        ack_c = cur_c; first_pre = -1; first_arf = -1; drop_c = -1; req_after_ack = 1;
        for (int i = 0; i < 8; i++) begin
            step(0);
            if (cur_c == ack_c + 1) req_after_ack = ref_req;
            if (cur_cmd == C_PRE && first_pre < 0) first_pre = cur_c;
            if (cur_cmd == C_ARF && first_arf < 0) first_arf = cur_c;
            if (!ref_busy && drop_c < 0) drop_c = cur_c;
        end
        check("ack_to_precharge", first_pre - ack_c, 1);
        check("ack_to_aref", first_arf - ack_c, 3);
        check("ack_to_busy_low", drop_c - ack_c, 6);
        check("req_cleared_on_ack", req_after_ack, 0);

        // Refresh exit on the same edge as an interval wrap.
        while (mc < D + 3 * REF - 1 - 5) step(0);
        step(1);
        while (mc <= D + 3 * REF) step(0);
        check("collide_req_reasserted", ref_req, 1);
        check("collide_busy_low", ref_busy, 0);
        check("collide_no_overrun", ref_overrun, 0);

        // Random ack traffic with varying rates and one mid-run reset.
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = $urandom_range(0, 2);
            for (int i = 0; i < 200; i++) begin
                bit a;
                case (rate)
                    0:       a = 1'b0;
                    1:       a = ($urandom_range(0, 19) == 0);
                    default: a = 1'($urandom_range(0, 1));
                endcase
                step(a);
            end
            if (seg == 4) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
